serial_rx: RTL and testbench
============================

Name: serial_rx

Overview:
- Receive stage directly downstream of the b13-style serial transmitter.
- Consumes the transmitter's `data_out` line, where each symbol is a one-cycle pulse: line is high between symbols, symbols are spaced `BIT_PERIOD` clocks apart.
- Frame: start (0), 8 data bits MSB first, stop (1).
- Rebuilds bytes, checks framing, buffers them in a small FIFO toward a valid/ready consumer, and drives `dsr` back to the transmitter as flow control.

Parameters:
- `BIT_PERIOD`, 106: clocks between consecutive symbol pulses. Equals transmitter DelayTime 104 + 2.
- `DEPTH`, 2: FIFO entries. Legal values are 1..4.
- `CNT_W`, 10: width of the bit-period counter. Must satisfy 2^CNT_W > BIT_PERIOD.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `serial_in`  in  1  serial line from the transmitter's `data_out`; idle level 1.
- `rx_data`  out  8  head-of-FIFO byte; valid only when `rx_valid`=1.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts the head byte when `rx_valid`&`rx_ready`.
- `dsr`  out  1  receiver can accept a frame; feeds the transmitter's `dsr`.
- `frame_error`  out  1  one-cycle pulse: stop symbol sampled as 0.
- `overrun`  out  1  one-cycle pulse: good frame dropped because FIFO full.
- `err_count`  out  8  saturating count of `frame_error` plus `overrun` events.

Behaviour:
- Reset values:
  - state IDLE, counter 0, shift register 0, FIFO empty.
  - `rx_data`=0, `rx_valid`=0, `dsr`=1, `frame_error`=0, `overrun`=0, `err_count`=0.
- Reset mid-frame aborts the frame with no pulses. Reset has priority over every other event.
- State machine states: IDLE, DATA, STOP.
- IDLE:
  - `serial_in`=0 at cycle t → DATA, counter=0, bit index=7.
  - Otherwise stay in IDLE.
- DATA:
  - Counter increments each cycle.
  - When counter = `BIT_PERIOD`-1, sample `serial_in` into `shift[bit index]` and reset the counter to 0.
  - After index 0 is sampled → STOP.
  - Data bit k (MSB first) is therefore sampled at t+(8-k)*`BIT_PERIOD`.
  - The line is never sampled at any other cycle; glitches between pulses are ignored.
- STOP:
  - Sample at t+9*`BIT_PERIOD`, then → IDLE. A new start is accepted from the next cycle.
  - Sample 1 and FIFO not full → push the shift register.
  - Sample 1 and FIFO full → `overrun` pulse the following cycle; byte dropped.
  - Sample 0 → `frame_error` pulse the following cycle; byte dropped.
- FIFO:
  - Circular buffer with read/write pointers and a count register; pointers wrap modulo `DEPTH`.
  - Pop on `rx_valid`&`rx_ready`.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full: the push succeeds and no overrun is raised.
  - Pop when empty: ignored.
  - `rx_data` is combinationally the head entry. It is held stable while `rx_valid`=1 and no pop occurs.
- Latency: the pushed byte is visible (`rx_valid`=1) on the cycle after the stop sample.
- `dsr` is registered: `dsr`=(count < `DEPTH`), using next-cycle count.
- `err_count` increments by 1 per error pulse and saturates at 255. The two error pulses cannot coincide.
- Counter arithmetic is `CNT_W`-bit unsigned and never exceeds `BIT_PERIOD`-1.

Decomposition:
- Package `serial_pkg`:
  - State encoding: IDLE=2'b00, DATA=2'b01, STOP=2'b10; 2'b11 is illegal and recovers to IDLE.
  - Default `BIT_PERIOD` and `DATA_BITS`=8.
  - Symbol codes shared with the transmitter: START_BIT..BIT7.
- One natural sub-module: `serial_rx_fifo`, parameterised by `DEPTH`, width 8, with push/pop/count/full/empty.
- Framing FSM and counter stay in `serial_rx`.

Test Plan:
- Byte 8'hA5 driven with `BIT_PERIOD`=106 pulse spacing, `rx_ready`=1 → `rx_valid`=1 and `rx_data`=8'hA5 exactly 1 cycle after the stop sample (t+954+1), popped the same cycle. No errors.
- Frame 8'h3C with stop pulse forced to 0 → `frame_error`=1 for one cycle at t+955, `err_count`=1, `rx_valid` stays 0, IDLE accepts a start at t+955.
- `rx_ready`=0, three good frames 8'h01, 8'h02, 8'h03:
  - `dsr` drops to 0 after the second push.
  - The third frame raises `overrun`; `err_count`=1.
  - Raising `rx_ready` then pops 8'h01 followed by 8'h02.
- FIFO full with stop sample coinciding with a pop → no overrun; FIFO stays full with the new byte at the tail.
- Glitch lows on `serial_in` between data pulses, plus one-cycle line pulses at non-sample offsets → received byte equals the pulse-sampled value only.
- `reset` asserted at t+400 mid-frame, then a clean frame 8'hFF → no pulses from the aborted frame; 8'hFF received correctly; `err_count`=0.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants for the serial receive path
package serial_pkg;

  localparam int BIT_PERIOD_DEF = 106;
  localparam int DATA_BITS      = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_DATA = 2'b01;
  localparam logic [1:0] ST_STOP = 2'b10;

  // Symbol order on the line, shared with the transmitter.
  typedef enum logic [3:0] {
    START_BIT,
    BIT0,
    BIT1,
    BIT2,
    BIT3,
    BIT4,
    BIT5,
    BIT6,
    BIT7,
    STOP_BIT
  } symbol_e;

endpackage

// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - byte handshake between receiver and consumer
interface serial_rx_if;
  import serial_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/serial_rx_fifo.sv
// rtl/serial_rx_fifo.sv - small circular byte buffer with simultaneous push/pop
module serial_rx_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    head    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - pulse-line frame receiver with byte FIFO and dsr flow control
module serial_rx
  import serial_pkg::*;
#(
  parameter int BIT_PERIOD = BIT_PERIOD_DEF,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          serial_in,
  serial_rx_if.master   rx,
  output logic          dsr,
  output logic          frame_error,
  output logic          overrun,
  output logic [7:0]    err_count
);

  localparam int FCW = $clog2(DEPTH + 1);

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shift;

  logic                 sample;
  logic                 stop_sample;
  logic                 pop;
  logic                 push;
  logic                 ovr_now;
  logic                 ferr_now;
  logic [DATA_BITS-1:0] head;
  logic [FCW-1:0]       count;
  logic [FCW-1:0]       count_next;
  logic                 full;
  logic                 empty;

  assign rx.rx_data  = head;
  assign rx.rx_valid = !empty;

  always_comb begin
    sample      = (cnt == CNT_W'(BIT_PERIOD - 1));
    stop_sample = (state == ST_STOP) && sample;
    pop         = !empty && rx.rx_ready;
    push        = stop_sample && serial_in && (!full || pop);
    ovr_now     = stop_sample && serial_in && full && !pop;
    ferr_now    = stop_sample && !serial_in;
    count_next  = count + FCW'(push) - FCW'(pop);
  end

  serial_rx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // The line is only looked at on the counter wrap, so anything between pulses is ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= 3'd7;
      shift <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!serial_in) begin
            state <= ST_DATA;
            cnt   <= '0;
            idx   <= 3'd7;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shift[idx] <= serial_in;
            cnt        <= '0;
            if (idx == 3'd0) begin
              state <= ST_STOP;
            end else begin
              idx <= idx - 3'd1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (sample) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      err_count   <= 8'd0;
      dsr         <= 1'b1;
    end else begin
      frame_error <= ferr_now;
      overrun     <= ovr_now;
      if ((ferr_now || ovr_now) && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      dsr <= (count_next < FCW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb/tb_serial_rx.sv - randomized frame stimulus checked against a queue-based receiver model
module tb_serial_rx;
  import serial_pkg::*;

  localparam int BP    = 106;
  localparam int DEPTH = 2;
  localparam int NSYM  = 9 * BP;

  logic       clock = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       dsr;
  logic       frame_error;
  logic       overrun;
  logic [7:0] err_count;

  serial_rx_if rx ();

  serial_rx #(
    .BIT_PERIOD (BP),
    .DEPTH      (DEPTH),
    .CNT_W      (10)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_in   (serial_in),
    .rx          (rx),
    .dsr         (dsr),
    .frame_error (frame_error),
    .overrun     (overrun),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  int         total = 0;
  int         bad = 0;
  logic [7:0] q[$];
  int         errs = 0;
  bit         rand_ready = 1'b0;
  logic [7:0] m_byte;
  logic       m_stop;
  logic       line [0:NSYM];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the edge from the receiver's rules, then compare every output.
  task automatic step(input bit ev);
    bit         pop_e;
    bit         fe_e;
    bit         ov_e;
    logic [7:0] want;
    fe_e = 1'b0;
    ov_e = 1'b0;
    if (rand_ready) rx.rx_ready = ($urandom_range(0, 1) == 1);
    if (reset) begin
      q.delete();
      errs = 0;
    end else begin
      pop_e = rx.rx_ready && (q.size() > 0);
      if (pop_e) begin
        want = q.pop_front();
        chk("pop_data", rx.rx_data, want);
      end
      if (ev) begin
        if (!m_stop) fe_e = 1'b1;
        else if (q.size() < DEPTH) q.push_back(m_byte);
        else ov_e = 1'b1;
        if ((fe_e || ov_e) && errs < 255) errs++;
      end
    end
    @(posedge clock);
    #1;
    chk("rx_valid", rx.rx_valid, q.size() > 0);
    chk("dsr", dsr, q.size() < DEPTH);
    chk("frame_error", frame_error, fe_e);
    chk("overrun", overrun, ov_e);
    chk("err_count", err_count, errs);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop, input bit glitch,
                            input int abort_at, input bit ready_at_stop);
    bit aborted;
    aborted = 1'b0;
    line[0] = 1'b0;
    for (int j = 1; j <= NSYM; j++) begin
      if (j % BP == 0) line[j] = (j == NSYM) ? stop : data[8 - j / BP];
      else line[j] = glitch ? ($urandom_range(0, 5) != 0) : 1'b1;
    end
    for (int k = 0; k < 8; k++) m_byte[k] = line[(8 - k) * BP];
    m_stop = line[NSYM];
    for (int j = 0; j <= NSYM && !aborted; j++) begin
      serial_in = line[j];
      if (j == abort_at) reset = 1'b1;
      if (ready_at_stop) rx.rx_ready = (j == NSYM);
      step((j == NSYM) && (j != abort_at));
      if (reset) begin
        reset   = 1'b0;
        aborted = 1'b1;
      end
    end
    if (ready_at_stop) rx.rx_ready = 1'b0;
    serial_in = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    serial_in   = 1'b1;
    rx.rx_ready = 1'b0;
    step(1'b0);
    chk("reset_rx_data", rx.rx_data, 8'h00);
    reset = 1'b0;
    idle(3);

    rx.rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, 1'b0, -1, 1'b0);
    chk("a5_data_after_stop", rx.rx_data, 8'hA5);
    idle(2);

    send_frame(8'h3C, 1'b0, 1'b0, -1, 1'b0);
    chk("ferr_count", err_count, 8'd1);
    send_frame(8'h5A, 1'b1, 1'b0, -1, 1'b0);
    idle(2);

    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    rx.rx_ready = 1'b0;
    send_frame(8'h01, 1'b1, 1'b0, -1, 1'b0);
    chk("dsr_after_one", dsr, 1'b1);
    send_frame(8'h02, 1'b1, 1'b0, -1, 1'b0);
    chk("dsr_after_two", dsr, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0, -1, 1'b0);
    chk("ovr_count", err_count, 8'd1);
    send_frame(8'h77, 1'b1, 1'b0, -1, 1'b1);
    chk("coinc_count", err_count, 8'd1);
    chk("coinc_head", rx.rx_data, 8'h02);
    rx.rx_ready = 1'b1;
    idle(4);

    send_frame(8'($urandom), 1'b1, 1'b1, -1, 1'b0);
    idle(2);

    send_frame(8'h96, 1'b1, 1'b0, 400, 1'b0);
    idle(1000);
    send_frame(8'hFF, 1'b1, 1'b0, -1, 1'b0);
    chk("abort_err_count", err_count, 8'd0);
    idle(2);

    rand_ready = 1'b1;
    for (int f = 0; f < 6; f++) begin
      send_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'b1, -1, 1'b0);
    end
    rand_ready  = 1'b0;
    rx.rx_ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
